// File: rtl/nios_soc_led_driver.sv
// nios_soc_led_driver
//   Avalon-MM slave LED/pin driver with direct data, set/clear access,
//   a free-running blink overlay and a timed one-shot pulse with interrupt.
//
// Ports
//   clk        : single rising-edge clock
//   reset      : synchronous, active-high reset
//   address    : register select (0 DATA, 1 SET, 2 CLR, 3 BLINK_MASK,
//                4 BLINK_HALF, 5 PULSE, 6 STATUS, 7 IRQ_MASK)
//   chipselect : slave select; a write needs chipselect=1 and write_n=0
//   write_n    : active-low write strobe
//   writedata  : 32-bit write data
//   readdata   : registered read data, refreshed every clock from address
//   irq        : level interrupt, done & IRQ_MASK[0]
//   out_port   : driven LED/pin bits, registered
module nios_soc_led_driver #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned      PERIOD_W    = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [2:0] ADDR_DATA  = 3'd0;
  localparam logic [2:0] ADDR_SET   = 3'd1;
  localparam logic [2:0] ADDR_CLR   = 3'd2;
  localparam logic [2:0] ADDR_MASK  = 3'd3;
  localparam logic [2:0] ADDR_HALF  = 3'd4;
  localparam logic [2:0] ADDR_PULSE = 3'd5;
  localparam logic [2:0] ADDR_STAT  = 3'd6;
  localparam logic [2:0] ADDR_IRQM  = 3'd7;

  logic [WIDTH-1:0]    data_q,       data_d;
  logic [WIDTH-1:0]    blink_mask_q, blink_mask_d;
  logic [PERIOD_W-1:0] blink_half_q, blink_half_d;
  logic [PERIOD_W-1:0] blink_cnt_q,  blink_cnt_d;
  logic                phase_q,      phase_d;
  logic [WIDTH-1:0]    pulse_bits_q, pulse_bits_d;
  logic [15:0]         pulse_cnt_q,  pulse_cnt_d;
  logic                busy_q,       busy_d;
  logic                done_q,       done_d;
  logic                irq_mask_q,   irq_mask_d;
  logic [31:0]         readdata_q,   readdata_d;
  logic [WIDTH-1:0]    out_port_q,   out_port_d;

  logic        wr;
  logic [15:0] pulse_len;
  logic        pulse_end;
  logic        unused_wd;

  assign wr        = chipselect & ~write_n;
  assign pulse_len = writedata[31:16];
  assign unused_wd = ^writedata;

  always_comb begin
    data_d       = data_q;
    blink_mask_d = blink_mask_q;
    blink_half_d = blink_half_q;
    blink_cnt_d  = blink_cnt_q;
    phase_d      = phase_q;
    pulse_bits_d = pulse_bits_q;
    pulse_cnt_d  = pulse_cnt_q;
    busy_d       = busy_q;
    done_d       = done_q;
    irq_mask_d   = irq_mask_q;
    pulse_end    = 1'b0;

    if (wr) begin
      case (address)
        ADDR_DATA: data_d       = writedata[WIDTH-1:0];
        ADDR_SET:  data_d       = data_q | writedata[WIDTH-1:0];
        ADDR_CLR:  data_d       = data_q & ~writedata[WIDTH-1:0];
        ADDR_MASK: blink_mask_d = writedata[WIDTH-1:0];
        ADDR_IRQM: irq_mask_d   = writedata[0];
        default: ;
      endcase
    end

    // Blink: a half-period write restarts the cycle from phase 0.
    if (wr && address == ADDR_HALF) begin
      blink_half_d = writedata[PERIOD_W-1:0];
      blink_cnt_d  = '0;
      phase_d      = 1'b0;
    end else if (blink_half_q == '0) begin
      blink_cnt_d  = '0;
      phase_d      = 1'b0;
    end else if (blink_cnt_q == blink_half_q - PERIOD_W'(1)) begin
      blink_cnt_d  = '0;
      phase_d      = ~phase_q;
    end else begin
      blink_cnt_d  = blink_cnt_q + PERIOD_W'(1);
    end

    // Pulse: a non-zero length write (re)starts; a running pulse that is
    // restarted never reports completion of the aborted one.
    if (wr && address == ADDR_PULSE && pulse_len != 16'd0) begin
      pulse_bits_d = writedata[WIDTH-1:0];
      pulse_cnt_d  = pulse_len;
      busy_d       = 1'b1;
    end else if (busy_q) begin
      if (pulse_cnt_q == 16'd1) begin
        pulse_cnt_d  = 16'd0;
        pulse_bits_d = '0;
        busy_d       = 1'b0;
        pulse_end    = 1'b1;
      end else begin
        pulse_cnt_d  = pulse_cnt_q - 16'd1;
      end
    end

    // Completion beats a simultaneous software clear of done.
    if (wr && address == ADDR_STAT && writedata[1]) done_d = 1'b0;
    if (pulse_end) done_d = 1'b1;

    // Built from next-state values so a write shows one cycle later.
    out_port_d = (data_d ^ (blink_mask_d & {WIDTH{phase_d}})) | pulse_bits_d;

    case (address)
      ADDR_DATA, ADDR_SET, ADDR_CLR: readdata_d = 32'(data_q);
      ADDR_MASK:  readdata_d = 32'(blink_mask_q);
      ADDR_HALF:  readdata_d = 32'(blink_half_q);
      ADDR_STAT:  readdata_d = {30'd0, done_q, busy_q};
      ADDR_IRQM:  readdata_d = {31'd0, irq_mask_q};
      default:    readdata_d = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q       <= RESET_VALUE;
      blink_mask_q <= '0;
      blink_half_q <= '0;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b0;
      pulse_bits_q <= '0;
      pulse_cnt_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      irq_mask_q   <= 1'b0;
      readdata_q   <= '0;
      out_port_q   <= RESET_VALUE;
    end else begin
      data_q       <= data_d;
      blink_mask_q <= blink_mask_d;
      blink_half_q <= blink_half_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      pulse_bits_q <= pulse_bits_d;
      pulse_cnt_q  <= pulse_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      irq_mask_q   <= irq_mask_d;
      readdata_q   <= readdata_d;
      out_port_q   <= out_port_d;
    end
  end

  assign readdata = readdata_q;
  assign out_port = out_port_q;
  assign irq      = done_q & irq_mask_q;

endmodule

// File: tb/tb_nios_soc_led_driver.sv
// tb_nios_soc_led_driver
//   Directed-vector bench for nios_soc_led_driver (WIDTH=8, RESET_VALUE=0xA5).
//   Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_nios_soc_led_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic [7:0]  out_port;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] rd;

  nios_soc_led_driver #(
    .WIDTH       (8),
    .RESET_VALUE (8'hA5),
    .PERIOD_W    (24)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the write edge.
  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [31:0] d);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  initial begin
    reset      = 1'b1;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    @(negedge clk);
    @(negedge clk);
    check_vec("rst_out", 32'(out_port), 32'hA5);
    check_vec("rst_irq", 32'(irq), 32'd0);
    check_vec("rst_rdata", readdata, 32'd0);
    reset = 1'b0;

    // Data / set / clear
    wr_reg(3'd0, 32'h0F);  check_vec("data_wr", 32'(out_port), 32'h0F);
    wr_reg(3'd1, 32'h30);  check_vec("set_wr", 32'(out_port), 32'h3F);
    wr_reg(3'd2, 32'h03);  check_vec("clr_wr", 32'(out_port), 32'h3C);
    rd_reg(3'd0, rd);      check_vec("rd_data", rd, 32'h3C);
    rd_reg(3'd1, rd);      check_vec("rd_set", rd, 32'h3C);
    rd_reg(3'd5, rd);      check_vec("rd_pulse0", rd, 32'd0);

    // Blink with half-period 4
    wr_reg(3'd0, 32'h00);
    wr_reg(3'd3, 32'h01);
    check_vec("mask_nohalf", 32'(out_port), 32'h00);
    wr_reg(3'd4, 32'd4);
    for (int i = 0; i < 12; i++) begin
      check_vec("blink", 32'(out_port), ((i / 4) % 2 == 1) ? 32'h01 : 32'h00);
      @(negedge clk);
    end
    rd_reg(3'd4, rd);      check_vec("rd_half", rd, 32'd4);
    wr_reg(3'd4, 32'd0);
    for (int i = 0; i < 6; i++) begin
      check_vec("blink_off", 32'(out_port), 32'h00);
      @(negedge clk);
    end

    // Pulse of 3 cycles on bit 7 with interrupt
    wr_reg(3'd7, 32'd1);
    wr_reg(3'd5, 32'h0003_0080);
    for (int i = 0; i < 4; i++) begin
      check_vec("pulse3_out", 32'(out_port), (i < 3) ? 32'h80 : 32'h00);
      check_vec("pulse3_irq", 32'(irq), (i < 3) ? 32'd0 : 32'd1);
      @(negedge clk);
    end
    rd_reg(3'd6, rd);      check_vec("stat_done", rd, 32'h2);
    wr_reg(3'd6, 32'h2);   check_vec("irq_clr", 32'(irq), 32'd0);
    rd_reg(3'd6, rd);      check_vec("stat_clr", rd, 32'h0);

    // Zero-length pulse is ignored
    wr_reg(3'd5, 32'h0000_00FF);
    check_vec("pulse0_out", 32'(out_port), 32'h00);
    rd_reg(3'd6, rd);      check_vec("pulse0_stat", rd, 32'h0);

    // Restart a running pulse
    wr_reg(3'd5, 32'h0005_0001);
    check_vec("rs_a0", 32'(out_port), 32'h01);
    @(negedge clk);
    check_vec("rs_a1", 32'(out_port), 32'h01);
    wr_reg(3'd5, 32'h0002_0002);
    check_vec("rs_b0", 32'(out_port), 32'h02);
    check_vec("rs_b0_irq", 32'(irq), 32'd0);
    @(negedge clk);
    check_vec("rs_b1", 32'(out_port), 32'h02);
    check_vec("rs_b1_irq", 32'(irq), 32'd0);
    @(negedge clk);
    check_vec("rs_end", 32'(out_port), 32'h00);
    check_vec("rs_end_irq", 32'(irq), 32'd1);
    wr_reg(3'd6, 32'h2);
    repeat (4) @(negedge clk);
    check_vec("rs_once_irq", 32'(irq), 32'd0);
    rd_reg(3'd6, rd);      check_vec("rs_once_stat", rd, 32'h0);

    // Done-clear in the same cycle the pulse ends: set wins
    wr_reg(3'd5, 32'h0002_0004);
    @(negedge clk);
    check_vec("race_out", 32'(out_port), 32'h04);
    wr_reg(3'd6, 32'h2);
    check_vec("race_end", 32'(out_port), 32'h00);
    check_vec("race_irq", 32'(irq), 32'd1);
    rd_reg(3'd6, rd);      check_vec("race_stat", rd, 32'h2);
    wr_reg(3'd6, 32'h2);   check_vec("race_clr", 32'(irq), 32'd0);

    // Reset during pulse + blink, with a simultaneous write
    wr_reg(3'd3, 32'hF0);
    wr_reg(3'd4, 32'd3);
    wr_reg(3'd5, 32'h000A_0001);
    @(negedge clk);
    check_vec("pre_rst_out", 32'(out_port), 32'h01);
    reset      = 1'b1;
    address    = 3'd0;
    writedata  = 32'h11;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    reset      = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    check_vec("mid_rst_irq", 32'(irq), 32'd0);
    for (int i = 0; i < 12; i++) begin
      check_vec("mid_rst_out", 32'(out_port), 32'hA5);
      @(negedge clk);
    end
    rd_reg(3'd6, rd);      check_vec("mid_rst_stat", rd, 32'h0);
    rd_reg(3'd3, rd);      check_vec("mid_rst_mask", rd, 32'h0);
    rd_reg(3'd4, rd);      check_vec("mid_rst_half", rd, 32'h0);
    rd_reg(3'd0, rd);      check_vec("mid_rst_data", rd, 32'hA5);
    check_vec("mid_rst_irq2", 32'(irq), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nios_soc_led_driver.md
NIOS_SOC_LED_DRIVER -- requirements
Module: nios_soc_led_driver

Interface
REQ-001 Parameter WIDTH, default 8, number of output bits on out_port.
REQ-002 Parameter RESET_VALUE, default 0, DATA register value after reset.
REQ-003 Parameter PERIOD_W, default 24, width of the blink half-period register and counter.
REQ-004 Port clk  input  1  single clock; all logic is rising-edge triggered.
REQ-005 Port reset  input  1  reset, synchronous and active-high.
REQ-006 Port address  input  3  Avalon-MM slave register select.
REQ-007 Port chipselect  input  1  slave select.
REQ-008 Port write_n  input  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
REQ-009 Port writedata  input  32  write data.
REQ-010 Port readdata  output  32  registered read data.
REQ-011 Port irq  output  1  level interrupt.
REQ-012 Port out_port  output  WIDTH  driven LED/pin bits.

Function
REQ-013 Register map SHALL be:
- 0 DATA: read/write.
- 1 SET: write-1-to-set DATA bits; reads return DATA.
- 2 CLR: write-1-to-clear DATA bits; reads return DATA.
- 3 BLINK_MASK: read/write.
- 4 BLINK_HALF: read/write, PERIOD_W bits.
- 5 PULSE: write-only; reads return 0.
- 6 STATUS: bit0 busy, bit1 done.
- 7 IRQ_MASK: bit0 only.
REQ-014 readdata SHALL be updated every clock, independent of chipselect, with the mux value for the current address; unused bits are 0; read latency is 1 cycle; reads have no side effects.
REQ-015 out_port SHALL equal (DATA ^ (BLINK_MASK & {WIDTH{phase}})) | pulse_bits, registered, so a register write becomes visible on out_port 1 cycle after the write cycle.
REQ-016 Blink counter SHALL increment each cycle while BLINK_HALF != 0; on reaching BLINK_HALF-1 it wraps to 0 and toggles phase; phase therefore toggles every BLINK_HALF cycles.
REQ-017 A write to BLINK_HALF SHALL clear the counter and phase in the same cycle.
REQ-018 When BLINK_HALF == 0 the counter and phase SHALL hold at 0.
REQ-019 A write to PULSE with writedata[31:16] = L != 0 SHALL load pulse_bits = writedata[WIDTH-1:0] and the pulse counter = L, and set busy.
REQ-020 While busy, the pulse counter SHALL decrement by 1 each cycle; on the transition from 1 to 0, pulse_bits clear, busy clears, and done sets. pulse_bits are therefore present on out_port for exactly L cycles.
REQ-021 A PULSE write with L == 0 SHALL be ignored: no state change.
REQ-022 A PULSE write while busy SHALL restart the pulse with the new bits and length; done is unaffected.
REQ-023 A STATUS write with writedata[1]=1 SHALL clear done; if pulse completion occurs in the same cycle, set wins and done = 1.
REQ-024 irq SHALL equal done & IRQ_MASK[0], combinational from the registers.
REQ-025 SET/CLR writes SHALL modify only the DATA bits selected by writedata[WIDTH-1:0].

Reset
REQ-026 On reset=1 at a clock edge, the following SHALL take these values:
- DATA = RESET_VALUE.
- BLINK_MASK, BLINK_HALF, blink counter, phase, pulse_bits, pulse counter, busy, done, IRQ_MASK = 0.
- readdata = 0.
REQ-027 out_port SHALL equal RESET_VALUE in the cycle after reset, and irq SHALL equal 0.
REQ-028 Reset asserted mid-pulse or mid-blink SHALL abort the operation, and done SHALL NOT be set.
REQ-029 Reset SHALL take priority over any simultaneous write.

Verification
REQ-030 Scenario: write DATA=0x0F, then SET 0x30, then CLR 0x03 -> out_port shows 0x0F, 0x3F, 0x3C, each 1 cycle after its write; reading address 0 returns 0x3C.
REQ-031 Scenario: BLINK_MASK=0x01, BLINK_HALF=4, DATA=0 -> out_port[0] toggles every 4 cycles; a later write BLINK_HALF=0 -> out_port[0] holds 0.
REQ-032 Scenario: IRQ_MASK=1, PULSE write 0x0003_0080 -> out_port[7]=1 for exactly 3 cycles, then busy=0, done=1, irq=1; STATUS write 0x2 -> irq=0.
REQ-033 Scenario: PULSE L=5 with bits 0x01, then after 2 cycles PULSE L=2 with bits 0x02 -> bit0 drops, bit1 is high for 2 cycles, and done sets once.
REQ-034 Scenario: STATUS done-clear write in the exact cycle the pulse ends -> done reads 1 afterwards.
REQ-035 Scenario: reset asserted during an active pulse with blink running -> out_port=RESET_VALUE, STATUS=0, irq=0.
